// File: rtl/id_stage.sv
// id_stage -- instruction decode / register-read stage of the RISCKY 16-bit core.
//
// Decodes the four IR nibbles, reads two operands from a 16 x 16-bit register
// file (R0 hard-wired to zero, write-through bypass from write-back), builds the
// sign-extended immediate and registers everything into the ID/EX boundary.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   out_15_12/11_8/7_4/3_0      opcode, rd, rs1/imm8 hi, rs2/imm4/imm8 lo
//   pc_in, in_valid             instruction address and liveness from the IR
//   stall, flush                hold / kill the ID/EX register (flush wins)
//   wb_en, wb_addr, wb_data     register-file write-back port
//   ex_*                        registered ID/EX outputs
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  out_15_12,
  input  logic [3:0]  out_11_8,
  input  logic [3:0]  out_7_4,
  input  logic [3:0]  out_3_0,
  input  logic [15:0] pc_in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [15:0] ex_imm,
  output logic [15:0] ex_pc
);

  function automatic logic signed [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  logic [15:0] rf_q [16];

  logic               is_i4;
  logic               is_i8;
  logic [3:0]         src_a;
  logic [3:0]         src_b;
  logic               wr_hit;
  logic [15:0]        a_d;
  logic [15:0]        b_d;
  logic signed [15:0] imm_d;

  assign is_i4  = out_15_12[3] & ~out_15_12[2];
  assign is_i8  = out_15_12[3] &  out_15_12[2];
  // I8 formats (store/branch) read rd as their source; B reads R0, i.e. zero.
  assign src_a  = is_i8 ? out_11_8 : out_7_4;
  assign src_b  = is_i8 ? 4'h0     : out_3_0;
  assign wr_hit = wb_en && (wb_addr != 4'h0);

  // Reads: R0 is constant zero; a same-cycle write to the source bypasses the array.
  assign a_d = (src_a == 4'h0)                 ? 16'h0000 :
               (wr_hit && (wb_addr == src_a))  ? wb_data  : rf_q[src_a];
  assign b_d = (src_b == 4'h0)                 ? 16'h0000 :
               (wr_hit && (wb_addr == src_b))  ? wb_data  : rf_q[src_b];

  always_comb begin
    imm_d = 16'sh0000;
    if (is_i4)
      imm_d = sext4(out_3_0);
    else if (is_i8)
      imm_d = sext8({out_7_4, out_3_0});
  end

  // Register file; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        rf_q[i] <= 16'h0000;
    end else if (wr_hit) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // ID/EX boundary: flush clears, otherwise stall holds, otherwise load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      ex_valid  <= 1'b0;
      ex_opcode <= 4'h0;
      ex_rd     <= 4'h0;
      ex_a      <= 16'h0000;
      ex_b      <= 16'h0000;
      ex_imm    <= 16'h0000;
      ex_pc     <= 16'h0000;
    end else if (!stall) begin
      ex_valid  <= in_valid;
      ex_opcode <= out_15_12;
      ex_rd     <= out_11_8;
      ex_a      <= a_d;
      ex_b      <= b_d;
      ex_imm    <= imm_d;
      ex_pc     <= pc_in;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  out_15_12, out_11_8, out_7_4, out_3_0;
  logic [15:0] pc_in;
  logic        in_valid, stall, flush, wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm, ex_pc;

  id_stage dut (
    .clk(clk), .reset(reset),
    .out_15_12(out_15_12), .out_11_8(out_11_8), .out_7_4(out_7_4), .out_3_0(out_3_0),
    .pc_in(pc_in), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] imm, input logic [15:0] pc);
    exp_t e;
    e.op = op; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  task automatic set_ins(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] f74,
                         input logic [3:0] f30, input logic [15:0] pc, input logic vin);
    out_15_12 = op; out_11_8 = rd; out_7_4 = f74; out_3_0 = f30; pc_in = pc; in_valid = vin;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] addr, input logic [15:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  // One clock: the expected ID/EX contents (if live) are queued at the edge.
  task automatic tick(input bit push, input exp_t e);
    @(posedge clk);
    if (push) begin
      sb.push_back(e);
      last_e = e;
    end
    #1;
  endtask

  // Monitor: every live ID/EX cycle consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && ex_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: ex_valid=1 with pc=%h, expected nothing live", ex_pc);
        end else begin
          e = sb.pop_front();
          chk("ex_opcode", {12'h0, ex_opcode}, {12'h0, e.op});
          chk("ex_rd",     {12'h0, ex_rd},     {12'h0, e.rd});
          chk("ex_a",      ex_a,   e.a);
          chk("ex_b",      ex_b,   e.b);
          chk("ex_imm",    ex_imm, e.imm);
          chk("ex_pc",     ex_pc,  e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    none = mk(4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ins(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
    set_wb(1'b0, 4'h0, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R5 = 1234, then read it so ID/EX holds nonzero fields.
    set_wb(1'b1, 4'h5, 16'h1234); tick(0, none);
    set_wb(1'b0, 4'h0, 16'h0);
    set_ins(4'h1, 4'h2, 4'h5, 4'h5, 16'h0010, 1'b1);
    tick(1, mk(4'h1, 4'h2, 16'h1234, 16'h1234, 16'h0000, 16'h0010));

    // Asynchronous reset mid-cycle clears outputs immediately.
    set_ins(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_valid",  {15'h0, ex_valid}, 16'h0);
    chk("rst_opcode", {12'h0, ex_opcode}, 16'h0);
    chk("rst_rd",     {12'h0, ex_rd}, 16'h0);
    chk("rst_a",      ex_a, 16'h0);
    chk("rst_b",      ex_b, 16'h0);
    chk("rst_imm",    ex_imm, 16'h0);
    chk("rst_pc",     ex_pc, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R5 was cleared by reset.
    set_ins(4'h1, 4'h2, 4'h5, 4'h5, 16'h0012, 1'b1);
    tick(1, mk(4'h1, 4'h2, 16'h0000, 16'h0000, 16'h0000, 16'h0012));

    // Write R3, R4 then R-type read.
    set_ins(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
    set_wb(1'b1, 4'h3, 16'hBEEF); tick(0, none);
    set_wb(1'b1, 4'h4, 16'h0011); tick(0, none);
    set_wb(1'b0, 4'h0, 16'h0);
    set_ins(4'h2, 4'h1, 4'h3, 4'h4, 16'h0040, 1'b1);
    tick(1, mk(4'h2, 4'h1, 16'hBEEF, 16'h0011, 16'h0000, 16'h0040));

    // Same-cycle bypass of R7.
    set_wb(1'b1, 4'h7, 16'hA5A5);
    set_ins(4'h0, 4'h2, 4'h7, 4'h3, 16'h0042, 1'b1);
    tick(1, mk(4'h0, 4'h2, 16'hA5A5, 16'hBEEF, 16'h0000, 16'h0042));

    // Write to R0 is discarded, including on the bypass path.
    set_wb(1'b1, 4'h0, 16'hFFFF);
    set_ins(4'h0, 4'h2, 4'h0, 4'h7, 16'h0044, 1'b1);
    tick(1, mk(4'h0, 4'h2, 16'h0000, 16'hA5A5, 16'h0000, 16'h0044));
    set_wb(1'b0, 4'h0, 16'h0);
    set_ins(4'h0, 4'h2, 4'h0, 4'h0, 16'h0046, 1'b1);
    tick(1, mk(4'h0, 4'h2, 16'h0000, 16'h0000, 16'h0000, 16'h0046));

    // Immediates.
    set_ins(4'h9, 4'h3, 4'h4, 4'hC, 16'h0050, 1'b1);
    tick(1, mk(4'h9, 4'h3, 16'h0011, 16'h0000, 16'hFFFC, 16'h0050));
    set_ins(4'hD, 4'h3, 4'h7, 4'hF, 16'h0052, 1'b1);
    tick(1, mk(4'hD, 4'h3, 16'hBEEF, 16'h0000, 16'h007F, 16'h0052));
    set_ins(4'hD, 4'h7, 4'h8, 4'h0, 16'h0054, 1'b1);
    tick(1, mk(4'hD, 4'h7, 16'hA5A5, 16'h0000, 16'hFF80, 16'h0054));

    // Stall 3 cycles with changing inputs; the R9 write still lands.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_wb(1'b1, 4'h9, 16'h0909);
      else        set_wb(1'b0, 4'h0, 16'h0);
      set_ins(4'h1, i[3:0], 4'h3, 4'h4, 16'h0060 + 16'(i), 1'b1);
      tick(1, last_e);
    end

    // Flush together with stall kills the boundary.
    flush = 1'b1;
    set_ins(4'h2, 4'h6, 4'h3, 4'h4, 16'h0066, 1'b1);
    tick(0, none);
    chk("flush_valid",  {15'h0, ex_valid}, 16'h0);
    chk("flush_opcode", {12'h0, ex_opcode}, 16'h0);
    chk("flush_a",      ex_a, 16'h0);
    chk("flush_pc",     ex_pc, 16'h0);
    flush = 1'b0; stall = 1'b0;

    // Release: next instruction appears after one cycle, reading R9.
    set_ins(4'h3, 4'h5, 4'h9, 4'h3, 16'h0070, 1'b1);
    tick(1, mk(4'h3, 4'h5, 16'h0909, 16'hBEEF, 16'h0000, 16'h0070));

    // Invalid input still loads but is not live.
    set_ins(4'h2, 4'h1, 4'h3, 4'h4, 16'h0072, 1'b0);
    tick(0, none);
    chk("invalid_valid", {15'h0, ex_valid}, 16'h0);
    chk("invalid_pc",    ex_pc, 16'h0072);

    // Back-to-back stream of 8 R-type instructions.
    for (int i = 0; i < 8; i++) begin
      set_ins(i[3:0], i[3:0], (i % 2 == 1) ? 4'h7 : 4'h3, 4'h4, 16'h0100 + 16'(2 * i), 1'b1);
      tick(1, mk(i[3:0], i[3:0], (i % 2 == 1) ? 16'hA5A5 : 16'hBEEF, 16'h0011,
                 16'h0000, 16'h0100 + 16'(2 * i)));
    end

    set_ins(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
    tick(0, none);
    tick(0, none);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
